// File: rtl/ws_responder.sv
// Wait-state responder: holds ws for a configurable number of cycles per read, then strobes one data word.
// Optional define WS_RESPONDER_LFSR_EN masks the captured wait count with a free-running 16-bit LFSR.
//
// state  | meaning
// IDLE   | no read in progress, ws low
// WAIT   | read accepted, ws high while the wait counter runs down
// ACK    | data strobed on entry; waiting for rd to drop
module ws_responder #(
  parameter int              DW       = 8,
  parameter int              CW       = 4,
  parameter logic [DW-1:0]   DATA_XOR = 8'hA5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd,
  input  logic [CW-1:0] wait_cfg,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          busy,
  output logic [DW-1:0] txn_cnt,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] TXN_ONE = {{(DW-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] n_start;
  logic          ws_nxt, vld_nxt, busy_nxt, perr_nxt;
  logic [DW-1:0] rdata_nxt, txn_nxt;

`ifdef WS_RESPONDER_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign n_start = wait_cfg & lfsr[CW-1:0];
`else
  assign n_start = wait_cfg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ws        <= 1'b0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      busy      <= 1'b0;
      txn_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ws        <= ws_nxt;
      rdata     <= rdata_nxt;
      rdata_vld <= vld_nxt;
      busy      <= busy_nxt;
      txn_cnt   <= txn_nxt;
      proto_err <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ws_nxt    = 1'b0;
    vld_nxt   = 1'b0;
    rdata_nxt = rdata;
    txn_nxt   = txn_cnt;
    perr_nxt  = proto_err;
    case (state)
      S_IDLE: begin
        if (rd) begin
          if (n_start != '0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = n_start;
            ws_nxt    = 1'b1;
          end else begin
            state_nxt = S_ACK;
            vld_nxt   = 1'b1;
            rdata_nxt = txn_cnt ^ DATA_XOR;
            txn_nxt   = txn_cnt + TXN_ONE;
          end
        end
      end
      S_WAIT: begin
        if (!rd) begin
          // requester abandoned the read while we were still stalling it
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          perr_nxt  = 1'b1;
        end else if (cnt == CNT_ONE) begin
          state_nxt = S_ACK;
          cnt_nxt   = '0;
          vld_nxt   = 1'b1;
          rdata_nxt = txn_cnt ^ DATA_XOR;
          txn_nxt   = txn_cnt + TXN_ONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
          ws_nxt  = 1'b1;
        end
      end
      S_ACK: begin
        if (!rd) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_ws_responder.sv
// Self-checking bench for ws_responder: directed and randomized reads against a transaction-level model.
module tb_ws_responder;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd = 1'b0;
  logic [CW-1:0] wait_cfg = '0;
  logic          ws, rdata_vld, busy, proto_err;
  logic [DW-1:0] rdata, txn_cnt;

  int   checks = 0;
  int   errors = 0;
  int   m_cnt = 0;
  logic m_perr = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  ws_responder #(.DW(DW), .CW(CW), .DATA_XOR(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wait_cfg(wait_cfg),
    .ws(ws), .rdata(rdata), .rdata_vld(rdata_vld), .busy(busy),
    .txn_cnt(txn_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and compare every output; a data strobe consumes the current count.
  task automatic step_chk(input bit ws_e, input bit vld_e, input bit busy_e);
    @(posedge clk);
    #1;
    if (vld_e) begin
      m_rdata = 8'(m_cnt % 256) ^ 8'hA5;
      m_cnt++;
    end
    chk("ws", 32'(ws), 32'(ws_e));
    chk("rdata_vld", 32'(rdata_vld), 32'(vld_e));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt % 256));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  // One read: n wait cycles, optional drop of rd during wait cycle abort_k, hold extra ACK cycles.
  task automatic read_txn(input int n, input int abort_k, input int hold);
    wait_cfg = CW'(n);
    rd = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step_chk(1'b1, 1'b0, 1'b1);
      wait_cfg = CW'($urandom);
      if (k == abort_k) begin
        rd = 1'b0;
        m_perr = 1'b1;
        step_chk(1'b0, 1'b0, 1'b0);
        return;
      end
    end
    step_chk(1'b0, 1'b1, 1'b1);
    for (int h = 0; h < hold; h++) begin
      wait_cfg = CW'($urandom);
      step_chk(1'b0, 1'b0, 1'b1);
    end
    rd = 1'b0;
    wait_cfg = CW'($urandom);
    step_chk(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n, ab, hold;
    reset_n = 1'b0;
    #2;
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step_chk(1'b0, 1'b0, 1'b0);

    read_txn(3, -1, 1);
    read_txn(0, -1, 0);
    read_txn(0, -1, 0);
    chk("two_zero_wait_reads", 32'(txn_cnt), 32'd3);
    read_txn(5, 2, 0);
    repeat (3) step_chk(1'b0, 1'b0, 1'b0);
    read_txn(2, -1, 0);

    for (int i = 0; i < 30; i++) begin
      n = int'($urandom_range(0, 15));
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : -1;
      hold = int'($urandom_range(0, 2));
      read_txn(n, ab, hold);
      if ($urandom_range(0, 1) == 1) step_chk(1'b0, 1'b0, 1'b0);
    end

    // async reset while stalling the requester
    if (!m_perr) read_txn(4, 1, 0);
    wait_cfg = 4'd5;
    rd = 1'b1;
    step_chk(1'b1, 1'b0, 1'b1);
    step_chk(1'b1, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_ws", 32'(ws), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_proto_err", 32'(proto_err), 32'd0);
    chk("async_txn_cnt", 32'(txn_cnt), 32'd0);
    m_cnt = 0;
    m_perr = 1'b0;
    m_rdata = 8'h00;
    rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step_chk(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 256; k++) read_txn(1, -1, 0);
    chk("wrap_txn_cnt", 32'(txn_cnt), 32'd0);
    read_txn(1, -1, 0);
    chk("post_wrap_rdata", 32'(rdata), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
